// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-client round-robin sequencer for a shared latency-LAT ALU
module alu_rr_arbiter #(
    parameter int N   = 2,
    parameter int M   = 4,
    parameter int LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    input  logic         i_req1_valid,
    output logic         o_req0_ready,
    output logic         o_req1_ready,
    input  logic [N-1:0] i_req0_op,
    input  logic [N-1:0] i_req1_op,
    input  logic [M-1:0] i_req0_A,
    input  logic [M-1:0] i_req1_A,
    input  logic [M-1:0] i_req0_B,
    input  logic [M-1:0] i_req1_B,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_A,
    output logic [M-1:0] o_alu_B,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t     state_q;
    logic       ptr_q;
    logic [2:0] cnt_q;
    logic       id_q;

    logic       any_valid;
    logic       grant_d;

    // Grant selection: a lone requester wins outright, a tie goes to the priority pointer
    always_comb begin
        any_valid = i_req0_valid | i_req1_valid;
        grant_d   = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_d = ptr_q;
        end else if (i_req1_valid) begin
            grant_d = 1'b1;
        end
    end

    // Readies depend only on state and valids, never on any ready, and are held low in reset
    always_comb begin
        o_req0_ready = !i_reset && (state_q == S_IDLE) && i_req0_valid && !grant_d;
        o_req1_ready = !i_reset && (state_q == S_IDLE) && i_req1_valid &&  grant_d;
        o_busy       = (state_q != S_IDLE);
    end

    // Sequencer: accept one request, wait out the ALU latency, hold the response until taken
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            cnt_q        <= 3'd0;
            id_q         <= 1'b0;
            o_alu_op     <= '0;
            o_alu_A      <= '0;
            o_alu_B      <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_status <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        if (grant_d) begin
                            o_alu_op <= i_req1_op;
                            o_alu_A  <= i_req1_A;
                            o_alu_B  <= i_req1_B;
                        end else begin
                            o_alu_op <= i_req0_op;
                            o_alu_A  <= i_req0_A;
                            o_alu_B  <= i_req0_B;
                        end
                        id_q    <= grant_d;
                        cnt_q   <= LAT_CNT;
                        ptr_q   <= ~grant_d;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        o_rsp_result <= i_alu_result;
                        o_rsp_status <= i_alu_status;
                        o_rsp_id     <= id_q;
                        o_rsp_valid  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - randomized scoreboard bench for alu_rr_arbiter with a delay-stub ALU
`timescale 1ns/1ps
module tb_alu_rr_arbiter;

    localparam int N   = 2;
    localparam int M   = 4;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0, v1, r0, r1;
    logic [N-1:0] op0, op1;
    logic [M-1:0] a0, a1, b0, b1;
    logic [N-1:0] alu_op;
    logic [M-1:0] alu_a, alu_b;
    logic [M-1:0] alu_result;
    logic [3:0]   alu_status;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [M-1:0] rsp_result;
    logic [3:0]   rsp_status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N(N), .M(M), .LAT(LAT)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req0_valid (v0),
        .i_req1_valid (v1),
        .o_req0_ready (r0),
        .o_req1_ready (r1),
        .i_req0_op    (op0),
        .i_req1_op    (op1),
        .i_req0_A     (a0),
        .i_req1_A     (a1),
        .i_req0_B     (b0),
        .i_req1_B     (b1),
        .o_alu_op     (alu_op),
        .o_alu_A      (alu_a),
        .o_alu_B      (alu_b),
        .i_alu_result (alu_result),
        .i_alu_status (alu_status),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_status (rsp_status),
        .o_busy       (busy)
    );

    function automatic logic [M-1:0] fn_res(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
        return a ^ {b[0], b[M-1:1]} ^ M'(op);
    endfunction

    function automatic logic [3:0] fn_sta(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
        return {op, a[M-1], b[0]};
    endfunction

    // Delay-stub ALU: output reflects the operands seen LAT edges earlier
    logic [M-1:0] pipe_r [LAT];
    logic [3:0]   pipe_s [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '0;
                pipe_s[i] <= '0;
            end
        end else begin
            pipe_r[0] <= fn_res(alu_op, alu_a, alu_b);
            pipe_s[0] <= fn_sta(alu_op, alu_a, alu_b);
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
                pipe_s[i] <= pipe_s[i-1];
            end
        end
    end
    assign alu_result = pipe_r[LAT-1];
    assign alu_status = pipe_s[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic         id;
        logic [M-1:0] res;
        logic [3:0]   sta;
    } rsp_t;
    rsp_t exp_q[$];

    // Reference model: idle / waiting LAT+1 cycles / holding response
    typedef enum int {M_IDLE, M_WAIT, M_RESP} mph_t;
    mph_t         mph       = M_IDLE;
    int           wait_left = 0;
    logic         mptr      = 1'b0;
    logic         prev_rst  = 1'b0;
    logic         after_rst = 1'b0;
    logic [N-1:0] cur_op;
    logic [M-1:0] cur_a, cur_b;

    always @(negedge clk) begin
        logic g, e0, e1;
        rsp_t e;
        if (rst) begin
            check("rst_ready0", r0, 0);
            check("rst_ready1", r1, 0);
            if (prev_rst) begin
                check("rst_busy", busy, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_out", {rsp_id, rsp_result, rsp_status}, 0);
                check("rst_alu_out", {alu_op, alu_a, alu_b}, 0);
            end
            mph       = M_IDLE;
            mptr      = 1'b0;
            exp_q.delete();
            prev_rst  = 1'b1;
            after_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (after_rst) begin
                check("post_rst_alu", {alu_op, alu_a, alu_b}, 0);
                after_rst = 1'b0;
            end
            case (mph)
                M_IDLE: begin
                    check("idle_busy", busy, 0);
                    check("idle_rsp_valid", rsp_valid, 0);
                    g  = (v0 && v1) ? mptr : !v0;
                    e0 = v0 && (g == 1'b0);
                    e1 = v1 && (g == 1'b1);
                    check("grant_ready0", r0, e0);
                    check("grant_ready1", r1, e1);
                    if (v0 || v1) begin
                        cur_op = g ? op1 : op0;
                        cur_a  = g ? a1  : a0;
                        cur_b  = g ? b1  : b0;
                        e.id   = g;
                        e.res  = fn_res(cur_op, cur_a, cur_b);
                        e.sta  = fn_sta(cur_op, cur_a, cur_b);
                        exp_q.push_back(e);
                        mptr      = !g;
                        wait_left = LAT + 1;
                        mph       = M_WAIT;
                    end
                end
                M_WAIT: begin
                    check("wait_busy", busy, 1);
                    check("wait_rsp_valid", rsp_valid, 0);
                    check("wait_readies", {r0, r1}, 0);
                    check("wait_alu_fields", {alu_op, alu_a, alu_b}, {cur_op, cur_a, cur_b});
                    wait_left--;
                    if (wait_left == 0) mph = M_RESP;
                end
                default: begin
                    check("resp_busy", busy, 1);
                    check("resp_rsp_valid", rsp_valid, 1);
                    check("resp_readies", {r0, r1}, 0);
                    check("resp_alu_hold", {alu_op, alu_a, alu_b}, {cur_op, cur_a, cur_b});
                    if (rsp_ready) mph = M_IDLE;
                end
            endcase
        end
    end

    // Response monitor: compare every presented response against the scoreboard head
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_result", rsp_result, exp_q[0].res);
                check("rsp_status", rsp_status, exp_q[0].sta);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_req(input int p0, input int p1);
        v0  = ($urandom_range(0, 99) < p0);
        v1  = ($urandom_range(0, 99) < p1);
        op0 = N'($urandom);
        op1 = N'($urandom);
        a0  = M'($urandom);
        a1  = M'($urandom);
        b0  = M'($urandom);
        b1  = M'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        drive_req(100, 100);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c < 800) begin
                drive_req(40, 40);
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else if (c < 1600) begin
                drive_req(100, 100);
                rsp_ready = ($urandom_range(0, 4) != 0);
            end else begin
                drive_req(60, 60);
                rsp_ready = ($urandom_range(0, 5) == 0);
            end
            rst = (c > 50) && ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        v0        = 1'b0;
        v1        = 1'b0;
        rsp_ready = 1'b1;
        repeat (LAT + 10) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
